// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : START/DONE request and result bundle for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
   parameter int W = 8
);
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] inputa;
   logic [W-1:0] inputb;
   logic         sc_in;
   logic         busy;
   logic         done;
   logic [W-1:0] out;
   logic         sc_out;
   logic         zero;
   logic         parity;

   modport master (
      output start, op, inputa, inputb, sc_in,
      input  busy, done, out, sc_out, zero, parity
   );

   modport slave (
      input  start, op, inputa, inputb, sc_in,
      output busy, done, out, sc_out, zero, parity
   );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with registered result, one-bit-per-cycle
//               shifts/rotates and optional parity (macro SEQ_ALU_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
   parameter int W = 8
) (
   input  wire logic clk,
   input  wire logic reset_n,
   seq_alu_if.slave  bus
);
   localparam int SW = $clog2(W);

   localparam logic [2:0] c_op_and = 3'd0;
   localparam logic [2:0] c_op_lsh = 3'd1;
   localparam logic [2:0] c_op_rsh = 3'd2;
   localparam logic [2:0] c_op_xor = 3'd3;
   localparam logic [2:0] c_op_add = 3'd4;
   localparam logic [2:0] c_op_sub = 3'd5;
   localparam logic [2:0] c_op_rol = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_work;
   logic [SW-1:0] r_cnt;
   logic [2:0]    r_op;
   logic          r_fill;
   logic [W-1:0]  r_out;
   logic          r_sc_out;
   logic          r_zero;
   logic          r_done;
   logic          r_busy;

   logic [SW-1:0] w_n;
   logic          w_is_shift_op;
   logic          w_start_shift;
   logic [W:0]    w_sum;
   logic [W:0]    w_diff;
   logic [W-1:0]  w_alu_val;
   logic          w_alu_sc;
   logic [W-1:0]  w_step_val;
   logic          w_step_sc;
   logic          w_load_fin;
   logic [W-1:0]  w_fin_val;
   logic          w_fin_sc;

   assign w_n           = bus.inputb[SW-1:0];
   assign w_is_shift_op = (bus.op == c_op_lsh) || (bus.op == c_op_rsh) || (bus.op == c_op_rol);
   assign w_start_shift = w_is_shift_op && (w_n != '0);

   assign w_sum  = {1'b0, bus.inputa} + {1'b0, bus.inputb} + {{W{1'b0}}, bus.sc_in};
   assign w_diff = {1'b0, bus.inputa} + {1'b0, ~bus.inputb} + {{W{1'b0}}, 1'b1};

   // Shift ops only reach this path with n == 0, where the result is A unchanged.
   always_comb begin
      w_alu_val = '0;
      w_alu_sc  = 1'b0;
      case (bus.op)
         c_op_and: w_alu_val = bus.inputa & bus.inputb;
         c_op_xor: w_alu_val = bus.inputa ^ bus.inputb;
         c_op_add: {w_alu_sc, w_alu_val} = w_sum;
         c_op_sub: {w_alu_sc, w_alu_val} = w_diff;
         c_op_lsh, c_op_rsh, c_op_rol: w_alu_val = bus.inputa;
         default: ;
      endcase
   end

   always_comb begin
      w_step_val = r_work;
      w_step_sc  = 1'b0;
      case (r_op)
         c_op_lsh: begin
            w_step_val = {r_work[W-2:0], r_fill};
            w_step_sc  = r_work[W-1];
         end
         c_op_rsh: begin
            w_step_val = {r_fill, r_work[W-1:1]};
            w_step_sc  = r_work[0];
         end
         c_op_rol: begin
            w_step_val = {r_work[W-2:0], r_work[W-1]};
            w_step_sc  = r_work[W-1];
         end
         default: ;
      endcase
   end

   assign w_load_fin = ((r_state == ST_IDLE) && bus.start && !w_start_shift) ||
                       ((r_state == ST_SHIFT) && (r_cnt == SW'(1)));
   assign w_fin_val  = (r_state == ST_SHIFT) ? w_step_val : w_alu_val;
   assign w_fin_sc   = (r_state == ST_SHIFT) ? w_step_sc  : w_alu_sc;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_work   <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_fill   <= 1'b0;
         r_out    <= '0;
         r_sc_out <= 1'b0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         if (w_load_fin) begin
            r_out    <= w_fin_val;
            r_sc_out <= w_fin_sc;
            r_zero   <= (w_fin_val == '0);
         end
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_op   <= bus.op;
                  r_fill <= bus.sc_in;
                  r_busy <= 1'b1;
                  if (w_start_shift) begin
                     r_work  <= bus.inputa;
                     r_cnt   <= w_n;
                     r_state <= ST_SHIFT;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_FIN;
                  end
               end
            end
            ST_SHIFT: begin
               r_work <= w_step_val;
               r_cnt  <= r_cnt - SW'(1);
               if (r_cnt == SW'(1)) begin
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end
            end
            ST_FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SEQ_ALU_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_parity <= 1'b0;
      end else if (w_load_fin) begin
         r_parity <= ^w_fin_val;
      end
   end

   assign bus.parity = r_parity;
`else
   assign bus.parity = 1'b0;
`endif

   assign bus.out    = r_out;
   assign bus.sc_out = r_sc_out;
   assign bus.zero   = r_zero;
   assign bus.done   = r_done;
   assign bus.busy   = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed plus randomized self-checking bench for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
   localparam int W  = 8;
   localparam int SW = $clog2(W);

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   logic [W-1:0] hold_out;

   seq_alu_if #(.W(W)) bus ();

   seq_alu #(.W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour from the arithmetic definition of each opcode.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sc,
                                 output logic [W-1:0] r, output logic c, output int lat);
      longint unsigned mask, av, bv, full;
      int n;
      mask = (longint'(1) << W) - 1;
      av   = longint'(a);
      bv   = longint'(b);
      n    = int'(b[SW-1:0]);
      full = 0;
      c    = 1'b0;
      lat  = 0;
      case (op)
         3'd0: full = av & bv;
         3'd3: full = av ^ bv;
         3'd4: begin full = av + bv + longint'(sc); c = full[W]; end
         3'd5: begin full = (av - bv) & mask; c = (av >= bv); end
         3'd7: full = 0;
         default: begin
            if (n == 0) begin
               full = av;
            end else begin
               lat = n;
               if (op == 3'd1) begin
                  full = (av << n) | (sc ? ((longint'(1) << n) - 1) : 0);
                  c    = a[W-n];
               end else if (op == 3'd2) begin
                  full = (av >> n) | (sc ? (mask ^ (mask >> n)) : 0);
                  c    = a[n-1];
               end else begin
                  full = ((av << n) | (av >> (W - n))) & mask;
                  c    = full[0];
               end
            end
         end
      endcase
      r = full[W-1:0];
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sc, input bit noise);
      logic [W-1:0] er;
      logic         ec;
      int           lat;
      int           cyc;
      model(op, a, b, sc, er, ec, lat);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.inputa = a;
      bus.inputb = b;
      bus.sc_in  = sc;
      tick();
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 40) begin
         chk("busy_during_op", 32'(bus.busy), 32'd1);
         chk("out_held", 32'(bus.out), 32'(hold_out));
         if (noise) begin
            bus.start  = 1'($urandom_range(0, 1));
            bus.op     = 3'($urandom);
            bus.inputa = W'($urandom);
            bus.inputb = W'($urandom);
            bus.sc_in  = 1'($urandom);
         end
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      chk("done_latency", 32'(cyc), 32'(lat));
      chk("out", 32'(bus.out), 32'(er));
      chk("sc_out", 32'(bus.sc_out), 32'(ec));
      chk("zero", 32'(bus.zero), 32'(er == '0));
`ifdef SEQ_ALU_PARITY_EN
      chk("parity", 32'(bus.parity), 32'(^er));
`else
      chk("parity", 32'(bus.parity), 32'd0);
`endif
      hold_out = er;
      tick();
      chk("done_single_pulse", 32'(bus.done), 32'd0);
      chk("busy_after_fin", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      hold_out   = '0;
      reset_n    = 1'b0;
      bus.start  = 1'b0;
      bus.op     = '0;
      bus.inputa = '0;
      bus.inputb = '0;
      bus.sc_in  = 1'b0;
      tick();
      tick();
      chk("rst_out", 32'(bus.out), 32'd0);
      chk("rst_sc_out", 32'(bus.sc_out), 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd1);
      chk("rst_parity", 32'(bus.parity), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      reset_n = 1'b1;
      tick();

      run_op(3'd4, 8'hFF, 8'h01, 1'b0, 1'b0);
      run_op(3'd1, 8'h81, 8'h03, 1'b1, 1'b0);
      run_op(3'd2, 8'h81, 8'h01, 1'b0, 1'b0);
      run_op(3'd5, 8'h05, 8'h07, 1'b0, 1'b0);
      run_op(3'd6, 8'h81, 8'h07, 1'b0, 1'b1);
      run_op(3'd3, 8'hF0, 8'h0E, 1'b0, 1'b0);
      run_op(3'd1, 8'h5A, 8'h08, 1'b1, 1'b0);
      run_op(3'd7, 8'hFF, 8'hFF, 1'b1, 1'b0);
      run_op(3'd0, 8'hC3, 8'h3C, 1'b1, 1'b0);

      // Reset landing in the middle of a shift.
      hold_out   = 8'h11;
      run_op(3'd4, 8'h10, 8'h01, 1'b0, 1'b0);
      bus.start  = 1'b1;
      bus.op     = 3'd1;
      bus.inputa = 8'hAA;
      bus.inputb = 8'h05;
      bus.sc_in  = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("midrst_out", 32'(bus.out), 32'd0);
      chk("midrst_zero", 32'(bus.zero), 32'd1);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_sc_out", 32'(bus.sc_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("midrst_no_done", 32'(bus.done), 32'd0);
      end
      hold_out = '0;
      run_op(3'd0, 8'hF6, 8'h5F, 1'b0, 1'b0);

      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] b;
         b = W'($urandom);
         if ($urandom_range(0, 3) == 0) b[SW-1:0] = '0;
         run_op(3'($urandom), W'($urandom), b, 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
